// File: rtl/ex_muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_params -- shared types for the multiply/divide execution unit.
//
// Contents:
//   MulDivOperation  : operation code presented with a request
//                      (MULT, DIV, MTHI, MTLO).
//   MulDivResultData : HI/LO result pair at the default 32-bit operand width.
//                      Integrating code and benches use it to carry results.
// -----------------------------------------------------------------------------
package muldiv_params;

    typedef enum logic [1:0] {
        MULT = 2'd0,
        DIV  = 2'd1,
        MTHI = 2'd2,
        MTLO = 2'd3
    } MulDivOperation;

    localparam int MULDIV_RESULT_WIDTH = 32;

    typedef struct packed {
        logic [MULDIV_RESULT_WIDTH-1:0] high;
        logic [MULDIV_RESULT_WIDTH-1:0] low;
    } MulDivResultData;

endpackage

// File: rtl/ex_muldiv_unit_divider.sv
// -----------------------------------------------------------------------------
// muldiv_divider_core -- iterative restoring radix-2 divider.
//
// It works on operand magnitudes and produces one quotient bit per cycle. The
// first iteration happens on the start edge. The remaining DATA_WIDTH-1
// iterations follow on the next edges. The quotient and remainder are
// sign-corrected on the way out.
//
// Ports:
//   clock, reset_n      : clock, asynchronous active-low reset
//   start               : load operands and run the first iteration
//   abort               : stop an operation in flight (busy drops next edge)
//   dividend, divisor   : operands. The divisor must be non-zero.
//   is_signed           : treat the operands as two's complement
//   busy                : high while iterations remain
//   quotient, remainder : result. Valid once busy falls after a start.
// -----------------------------------------------------------------------------
module muldiv_divider_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  is_signed,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);
    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  busy_q, quo_neg_q, rem_neg_q;

    logic [DATA_WIDTH-1:0] mag_a, mag_b, src_rem, src_quo, src_dvs;
    logic [DATA_WIDTH-1:0] rem_step, quo_step;
    logic [DATA_WIDTH:0]   shifted, diff;

    // One restoring step. On start it runs on the fresh magnitudes with a zero
    // partial remainder. Otherwise it runs on the registered state.
    // NOTE: every always_comb output gets a value on every path, so no latches.
    always_comb begin
        mag_a   = (is_signed && dividend[DATA_WIDTH-1]) ? -dividend : dividend;
        mag_b   = (is_signed && divisor[DATA_WIDTH-1])  ? -divisor  : divisor;
        src_rem = start ? '0    : rem_q;
        src_quo = start ? mag_a : quo_q;
        src_dvs = start ? mag_b : dvs_q;
        shifted = {src_rem, src_quo[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, src_dvs};
        if (diff[DATA_WIDTH]) begin
            rem_step = shifted[DATA_WIDTH-1:0];
            quo_step = {src_quo[DATA_WIDTH-2:0], 1'b0};
        end else begin
            rem_step = diff[DATA_WIDTH-1:0];
            quo_step = {src_quo[DATA_WIDTH-2:0], 1'b1};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else if (abort) begin
            busy_q <= 1'b0;
        end else if (start) begin
            rem_q     <= rem_step;
            quo_q     <= quo_step;
            dvs_q     <= mag_b;
            cnt_q     <= CNT_W'(DATA_WIDTH - 1);
            busy_q    <= 1'b1;
            quo_neg_q <= is_signed & (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
            rem_neg_q <= is_signed & dividend[DATA_WIDTH-1];
        end else if (busy_q) begin
            rem_q  <= rem_step;
            quo_q  <= quo_step;
            cnt_q  <= cnt_q - CNT_W'(1);
            busy_q <= (cnt_q != CNT_W'(1));
        end
    end

    assign busy = busy_q;
    // Most-negative / -1 needs no special case here. Its magnitude quotient
    // negates back to the most-negative value, and its remainder is zero.
    assign quotient  = quo_neg_q ? -quo_q : quo_q;
    assign remainder = rem_neg_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// -----------------------------------------------------------------------------
// ex_muldiv_unit -- multiply/divide execution unit holding the HI/LO registers.
//
// Build option: MULDIV_DIVIDER_EN
//   defined   -> DIV uses the iterative divider core (done at DATA_WIDTH+1,
//                or at cycle 1 for a zero divisor).
//   undefined -> DIV completes at cycle 1 and leaves HI/LO unchanged. No
//                divider hardware is built.
//
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   request_valid/ready   : request handshake. Ready only in IDLE with cancel low.
//   request_operation     : MULT, DIV, MTHI, MTLO
//   request_signed        : signed multiply/divide
//   input1, input2        : operands (MTHI/MTLO take input1)
//   cancel                : flush any operation in flight
//   done                  : one-cycle completion pulse
//   high, low             : architectural HI/LO registers
// -----------------------------------------------------------------------------
module ex_muldiv_unit
    import muldiv_params::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  request_valid,
    output logic                  request_ready,
    input  MulDivOperation        request_operation,
    input  logic                  request_signed,
    input  logic [DATA_WIDTH-1:0] input1,
    input  logic [DATA_WIDTH-1:0] input2,
    input  logic                  cancel,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] high,
    output logic [DATA_WIDTH-1:0] low
);
    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

    state_t                  state_q, state_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   high_q, high_d, low_q, low_d;
    logic [CNT_W-1:0]        mul_cnt_q, mul_cnt_d;
    logic [DATA_WIDTH-1:0]   op_a_q, op_b_q;
    logic                    signed_q;

    logic                    accept;
    logic [DATA_WIDTH-1:0]   mul_a, mul_b;
    logic                    mul_sgn;
    logic signed [DATA_WIDTH:0] mul_a_ext, mul_b_ext;
    logic [2*DATA_WIDTH-1:0] product;

    assign request_ready = reset_n && (state_q == ST_IDLE) && !cancel;
    assign accept        = request_valid && request_ready;

    // With a one-cycle multiply the product comes straight from the request.
    // Otherwise it comes from the operands latched at accept.
    assign mul_a     = (state_q == ST_IDLE) ? input1         : op_a_q;
    assign mul_b     = (state_q == ST_IDLE) ? input2         : op_b_q;
    assign mul_sgn   = (state_q == ST_IDLE) ? request_signed : signed_q;
    // One extra bit lets a single signed multiplier cover both signednesses.
    assign mul_a_ext = {mul_sgn & mul_a[DATA_WIDTH-1], mul_a};
    assign mul_b_ext = {mul_sgn & mul_b[DATA_WIDTH-1], mul_b};
    assign product   = (2*DATA_WIDTH)'(mul_a_ext) * (2*DATA_WIDTH)'(mul_b_ext);

`ifdef MULDIV_DIVIDER_EN
    logic                  div_busy;
    logic [DATA_WIDTH-1:0] div_quotient, div_remainder;

    muldiv_divider_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_divider (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (accept && (request_operation == DIV) && (input2 != '0)),
        .abort     (cancel),
        .dividend  (input1),
        .divisor   (input2),
        .is_signed (request_signed),
        .busy      (div_busy),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );
`endif

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        high_d    = high_q;
        low_d     = low_q;
        mul_cnt_d = mul_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (request_operation)
                        MULT: begin
                            if (MUL_LATENCY == 1) begin
                                state_d         = ST_DONE;
                                done_d          = 1'b1;
                                {high_d, low_d} = product;
                            end else begin
                                state_d   = ST_MUL;
                                mul_cnt_d = CNT_W'(1);
                            end
                        end
                        DIV: begin
`ifdef MULDIV_DIVIDER_EN
                            if (input2 == '0) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                                low_d   = '1;
                                high_d  = input1;
                            end else begin
                                state_d = ST_DIV;
                            end
`else
                            state_d = ST_DONE;
                            done_d  = 1'b1;
`endif
                        end
                        MTHI: begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            high_d  = input1;
                        end
                        MTLO: begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            low_d   = input1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (mul_cnt_q == CNT_W'(MUL_LATENCY - 1)) begin
                    state_d         = ST_DONE;
                    done_d          = 1'b1;
                    {high_d, low_d} = product;
                end else begin
                    mul_cnt_d = mul_cnt_q + CNT_W'(1);
                end
            end
            ST_DIV: begin
`ifdef MULDIV_DIVIDER_EN
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (!div_busy) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    low_d   = div_quotient;
                    high_d  = div_remainder;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            high_q    <= '0;
            low_q     <= '0;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            high_q    <= high_d;
            low_q     <= low_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // NOTE: the operand registers are pure datapath. They are always written
    // at accept before anything reads them, so they need no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            op_a_q   <= input1;
            op_b_q   <= input2;
            signed_q <= request_signed;
        end
    end

    assign done = done_q;
    assign high = high_q;
    assign low  = low_q;

endmodule
